text_scanout: RTL and testbench
===============================

TEXT_SCANOUT -- requirements
Module: text_scanout

Interface
REQ-001 Parameter HORIZONTAL_WIDTH, default 1650, total horizontal count; sets width of sx/x ports ($clog2).
REQ-002 Parameter VERTICAL_WIDTH, default 750, total vertical count; sets width of sy/y ports ($clog2).
REQ-003 Parameter WIN_W, default 128, text window width in pixels (COLUMNS x 8).
REQ-004 Parameter WIN_H, default 304, text window height in pixels (ROWS x 16).
REQ-005 Parameter RD_LATENCY, default 2, fixed cycles from o_rd_en to i_rd_dv; legal 1..4.
REQ-006 Parameter FG_COLOR, default 24'hFFFFFF, glyph pixel color.
REQ-007 i_clk  in  1  sole clock, all logic rising-edge.
REQ-008 i_rst_n  in  1  asynchronous active-low reset.
REQ-009 i_sx / i_sy  in  $clog2(H)/$clog2(V)  current scan position.
REQ-010 i_de, i_hsync, i_vsync  in  1 each  video timing, aligned with i_sx/i_sy.
REQ-011 i_rgb  in  24  background video, aligned with i_sx/i_sy.
REQ-012 i_win_x / i_win_y  in  $clog2(H)/$clog2(V)  window origin.
REQ-013 i_wr_completed  in  1  character buffer fully written.
REQ-014 o_rd_en  out  1  pixel read request to overlay.
REQ-015 o_x / o_y  out  $clog2(H)/$clog2(V)  registered window origin sent with requests.
REQ-016 i_rd_dv / i_data  in  1/1  read response valid and glyph bit.
REQ-017 o_rgb  out  24; o_de, o_hsync, o_vsync  out  1 each  composited video.
REQ-018 o_status  out  2  sticky {overflow, underflow} (macro only, REQ-033).

Function
REQ-019 Video path (i_rgb, i_de, syncs, request tag) SHALL pass through a delay line of exactly PIPE = RD_LATENCY+2 cycles; output timing is i_* delayed by PIPE.
REQ-020 FSM SHALL have states IDLE, WAIT_FRAME, ACTIVE.
REQ-021 IDLE -> WAIT_FRAME when i_wr_completed=1; WAIT_FRAME -> ACTIVE on cycle with i_sx=0 and i_sy=0 (never start mid-frame); any state -> IDLE when i_wr_completed=0.
REQ-022 o_rd_en SHALL be high, registered (1 cycle after inputs), only in ACTIVE with i_de=1 and win_x <= sx < win_x+WIN_W and win_y <= sy < win_y+WIN_H; comparison in width+1 bits, no wrap.
REQ-023 o_x/o_y SHALL latch i_win_x/i_win_y only at frame start (sx=0, sy=0); mid-frame origin changes take effect next frame.
REQ-024 Each request SHALL set a tag bit in the delay line at the same pixel.
REQ-025 Responses SHALL be pushed into an 8-deep 1-bit FIFO when i_rd_dv=1.
REQ-026 When a tagged pixel exits the delay line, one FIFO entry SHALL be popped; o_rgb = FG_COLOR if bit=1 else delayed i_rgb.
REQ-027 Untagged pixels: o_rgb = delayed i_rgb; o_rgb = 0 whenever delayed de=0.
REQ-028 Pop on empty FIFO (underflow): pixel treated as bit 0, no pointer change.
REQ-029 Push on full FIFO (overflow): response dropped; simultaneous push+pop when full SHALL succeed (pop first).
REQ-030 Leaving ACTIVE stops new requests immediately; in-flight responses still drain and composite; FIFO flushed on entry to WAIT_FRAME.

Reset
REQ-031 While i_rst_n=0: state IDLE, FIFO empty, delay line zero, o_rd_en=0, o_x=o_y=0, o_rgb=0, o_de=o_hsync=o_vsync=0, o_status=0.
REQ-032 Reset mid-frame SHALL discard in-flight requests; after release ACTIVE not re-entered before next sx=0, sy=0.

Configuration
REQ-033 Macro TEXT_SCANOUT_STATUS_EN defined: o_status present; bit0 sets on underflow, bit1 on overflow, both sticky until reset or frame start in WAIT_FRAME. Undefined: o_status tied to 2'b00, no detection logic.

Verification
REQ-034 Reset asserted mid-frame, released -> all outputs 0; o_rd_en stays 0 until next (0,0) with i_wr_completed=1.
REQ-035 win=(100,50), wr_completed=1, overlay model latency 2 -> o_rd_en exactly for sx 100..227, sy 50..353; glyph bit 1 at (100,50) gives o_rgb=FFFFFF 4 cycles after input pixel.
REQ-036 i_wr_completed dropped mid-line -> o_rd_en low next cycle; outstanding 2 responses still composited; no further FG pixels.
REQ-037 Model withholds one i_rd_dv -> that pixel shows i_rgb; o_status=2'b01 (macro on), 2'b00 (macro off).
REQ-038 i_win_x changed 100->200 mid-frame -> o_x stays 100 until next frame start, then 200.
REQ-039 Model emits 9 extra dv pulses with no requests -> overflow, o_status[1]=1; later pixels still composite correctly after FIFO flush.

Source files
------------

// File: rtl/text_scanout_if.sv
// Glyph read channel between text_scanout (master) and the character overlay (slave).
// o_rd_en is a one-cycle request with no backpressure; the overlay must answer every
// request with exactly one i_rd_dv pulse (glyph bit on i_data) RD_LATENCY cycles later.
interface text_scanout_if #(
   parameter int XW = 11,
   parameter int YW = 10
);
   logic          o_rd_en;
   logic [XW-1:0] o_x;
   logic [YW-1:0] o_y;
   logic          i_rd_dv;
   logic          i_data;

   modport master (output o_rd_en, output o_x, output o_y, input i_rd_dv, input i_data);
   modport slave  (input o_rd_en, input o_x, input o_y, output i_rd_dv, output i_data);
endinterface

// File: rtl/text_scanout.sv
// Text window compositor: requests glyph bits for pixels inside the window and overlays them on delayed video.
// Optional macro TEXT_SCANOUT_STATUS_EN enables sticky {overflow, underflow} reporting on o_status.
module text_scanout #(
   parameter int          HORIZONTAL_WIDTH = 1650,
   parameter int          VERTICAL_WIDTH   = 750,
   parameter int          WIN_W            = 128,
   parameter int          WIN_H            = 304,
   parameter int          RD_LATENCY       = 2,
   parameter logic [23:0] FG_COLOR         = 24'hFFFFFF,
   localparam int         XW               = $clog2(HORIZONTAL_WIDTH),
   localparam int         YW               = $clog2(VERTICAL_WIDTH)
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic [XW-1:0]  i_sx,
   input  logic [YW-1:0]  i_sy,
   input  logic           i_de,
   input  logic           i_hsync,
   input  logic           i_vsync,
   input  logic [23:0]    i_rgb,
   input  logic [XW-1:0]  i_win_x,
   input  logic [YW-1:0]  i_win_y,
   input  logic           i_wr_completed,
   text_scanout_if.master rd_if,
   output logic [23:0]    o_rgb,
   output logic           o_de,
   output logic           o_hsync,
   output logic           o_vsync,
   output logic [1:0]     o_status,
   output logic [1:0]     o_state
);
   localparam int PIPE = RD_LATENCY + 2;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FRAME = 2'd1,
      ACTIVE     = 2'd2
   } state_t;

   typedef struct packed {
      logic        tag;
      logic        de;
      logic        hs;
      logic        vs;
      logic [23:0] rgb;
   } pix_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          w_flush;
   logic          w_frame_start;
   logic [XW-1:0] w_org_x;
   logic [YW-1:0] w_org_y;
   logic [XW:0]   w_x_end;
   logic [YW:0]   w_y_end;
   logic          w_in_win;
   logic          w_req;
   logic          r_rd_en;
   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   pix_t          r_dly [PIPE];
   pix_t          w_pix_in;
   pix_t          w_pix_out;
   logic [7:0]    r_fifo;
   logic [2:0]    r_wr_ptr;
   logic [2:0]    r_rd_ptr;
   logic [3:0]    r_count;
   logic          w_empty;
   logic          w_full;
   logic          w_pop_ok;
   logic          w_push_ok;
   logic          w_glyph;

   assign w_frame_start = (i_sx == '0) && (i_sy == '0);

   // At frame start the new origin is used directly so pixel (0,0) sees the same origin as the rest of the frame.
   assign w_org_x  = w_frame_start ? i_win_x : r_x;
   assign w_org_y  = w_frame_start ? i_win_y : r_y;
   assign w_x_end  = {1'b0, w_org_x} + (XW+1)'(WIN_W);
   assign w_y_end  = {1'b0, w_org_y} + (YW+1)'(WIN_H);
   assign w_in_win = (i_sx >= w_org_x) && ({1'b0, i_sx} < w_x_end) &&
                     (i_sy >= w_org_y) && ({1'b0, i_sy} < w_y_end);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_flush     = 1'b0;
      if (!i_wr_completed) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:       w_state_nxt = WAIT_FRAME;
            WAIT_FRAME: if (w_frame_start) w_state_nxt = ACTIVE;
            ACTIVE:     w_state_nxt = ACTIVE;
            default:    w_state_nxt = IDLE;
         endcase
      end
      w_flush = (r_state != WAIT_FRAME) && (w_state_nxt == WAIT_FRAME);
   end

   // Gating on the next state drops requests the same cycle i_wr_completed falls.
   assign w_req    = (w_state_nxt == ACTIVE) && i_de && w_in_win;
   assign w_pix_in = '{tag: w_req, de: i_de, hs: i_hsync, vs: i_vsync, rgb: i_rgb};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_en <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
         for (int i = 0; i < PIPE; i++) r_dly[i] <= '0;
      end else begin
         r_rd_en  <= w_req;
         if (w_frame_start) begin
            r_x <= i_win_x;
            r_y <= i_win_y;
         end
         r_dly[0] <= w_pix_in;
         for (int i = 1; i < PIPE; i++) r_dly[i] <= r_dly[i-1];
      end
   end

   assign w_pix_out = r_dly[PIPE-1];

   // Responses land one cycle before their pixel leaves the delay line, so the FIFO head is ready at pop time.
   assign w_empty   = (r_count == 4'd0);
   assign w_full    = (r_count == 4'd8);
   assign w_pop_ok  = w_pix_out.tag && !w_empty;
   assign w_push_ok = rd_if.i_rd_dv && (!w_full || w_pop_ok);
   assign w_glyph   = w_pop_ok && r_fifo[r_rd_ptr];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fifo   <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_fifo[r_wr_ptr] <= rd_if.i_data;
            r_wr_ptr         <= r_wr_ptr + 3'd1;
         end
         if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 3'd1;
         r_count <= r_count + {3'b000, w_push_ok} - {3'b000, w_pop_ok};
      end
   end

   always_comb begin
      o_rgb = '0;
      if (w_pix_out.de) o_rgb = w_glyph ? FG_COLOR : w_pix_out.rgb;
   end

   assign o_de          = w_pix_out.de;
   assign o_hsync       = w_pix_out.hs;
   assign o_vsync       = w_pix_out.vs;
   assign o_state       = r_state;
   assign rd_if.o_rd_en = r_rd_en;
   assign rd_if.o_x     = r_x;
   assign rd_if.o_y     = r_y;

`ifdef TEXT_SCANOUT_STATUS_EN
   logic [1:0] r_status;
   logic       w_unf;
   logic       w_ovf;
   logic       w_stat_clr;

   assign w_unf      = w_pix_out.tag && w_empty;
   assign w_ovf      = rd_if.i_rd_dv && w_full && !w_pop_ok;
   assign w_stat_clr = (r_state == WAIT_FRAME) && w_frame_start;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_status <= 2'b00;
      end else if (w_stat_clr) begin
         r_status <= 2'b00;
      end else begin
         r_status <= r_status | {w_ovf, w_unf};
      end
   end

   assign o_status = r_status;
`else
   assign o_status = 2'b00;
`endif
endmodule

// File: tb/tb_text_scanout.sv
// Directed bench for text_scanout: vector tables for window/compositing plus hand sequences for
// reset, withheld responses, early stop, origin change and FIFO overflow.
module tb_text_scanout;
   localparam int XW   = 11;
   localparam int YW   = 10;
   localparam int LAT  = 2;
   localparam int PIPE = LAT + 2;
   localparam int EW   = 27;
`ifdef TEXT_SCANOUT_STATUS_EN
   localparam logic STAT_EN = 1'b1;
`else
   localparam logic STAT_EN = 1'b0;
`endif

   typedef struct {
      logic          wr;
      logic [XW-1:0] sx;
      logic [YW-1:0] sy;
      logic          de;
      logic          hs;
      logic          vs;
      logic [23:0]   rgb;
      logic          exp_rd;
      logic [23:0]   exp_rgb;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [XW-1:0] i_sx;
   logic [YW-1:0] i_sy;
   logic          i_de;
   logic          i_hsync;
   logic          i_vsync;
   logic [23:0]   i_rgb;
   logic [XW-1:0] i_win_x;
   logic [YW-1:0] i_win_y;
   logic          i_wr_completed;
   logic [23:0]   o_rgb;
   logic          o_de;
   logic          o_hsync;
   logic          o_vsync;
   logic [1:0]    o_status;
   logic [1:0]    o_state;

   int            checks = 0;
   int            errors = 0;
   logic [EW-1:0] exp_q[$];
   vec_t          vt[$];

   // overlay model state
   logic [LAT-1:0] m_v;
   logic [LAT-1:0] m_d;
   logic [LAT-1:0] m_k;
   logic [XW-1:0]  sx_q;
   logic [YW-1:0]  sy_q;
   logic           extra_dv;
   logic [XW-1:0]  drop_x;
   logic [YW-1:0]  drop_y;

   text_scanout_if #(.XW(XW), .YW(YW)) rd_if ();

   text_scanout dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_sx           (i_sx),
      .i_sy           (i_sy),
      .i_de           (i_de),
      .i_hsync        (i_hsync),
      .i_vsync        (i_vsync),
      .i_rgb          (i_rgb),
      .i_win_x        (i_win_x),
      .i_win_y        (i_win_y),
      .i_wr_completed (i_wr_completed),
      .rd_if          (rd_if),
      .o_rgb          (o_rgb),
      .o_de           (o_de),
      .o_hsync        (o_hsync),
      .o_vsync        (o_vsync),
      .o_status       (o_status),
      .o_state        (o_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // Overlay model: glyph bit is 1 where (x+y) is a multiple of 3; answers LAT cycles after o_rd_en.
   function automatic logic glyph(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return ((int'(x) + int'(y)) % 3) == 0;
   endfunction

   always @(posedge clk) begin
      sx_q <= i_sx;
      sy_q <= i_sy;
      if (!rst_n) begin
         m_v <= '0;
         m_d <= '0;
         m_k <= '0;
      end else begin
         m_v <= {m_v[LAT-2:0], rd_if.o_rd_en};
         m_d <= {m_d[LAT-2:0], glyph(sx_q, sy_q)};
         m_k <= {m_k[LAT-2:0], (sx_q == drop_x) && (sy_q == drop_y)};
      end
   end

   assign rd_if.i_rd_dv = (m_v[LAT-1] && !m_k[LAT-1]) || extra_dv;
   assign rd_if.i_data  = extra_dv ? 1'b1 : m_d[LAT-1];

   // scoreboard
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic wr, input int sx, input int sy, input logic de,
                               input logic hs, input logic vs, input logic [23:0] rgb,
                               input logic exp_rd, input logic [23:0] exp_rgb);
      vec_t v;
      v.wr = wr; v.sx = XW'(sx); v.sy = YW'(sy); v.de = de; v.hs = hs; v.vs = vs;
      v.rgb = rgb; v.exp_rd = exp_rd; v.exp_rgb = exp_rgb;
      return v;
   endfunction

   function automatic vec_t idle(input logic wr);
      return mk(wr, 5, 5, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0);
   endfunction

   // driver: one pixel per call; checks o_rd_en now and the pixel that exits the delay line
   task automatic step(input vec_t v);
      logic [EW-1:0] e;
      i_wr_completed = v.wr;
      i_sx = v.sx; i_sy = v.sy; i_de = v.de;
      i_hsync = v.hs; i_vsync = v.vs; i_rgb = v.rgb;
      @(posedge clk);
      #1;
      check("rd_en", 32'(rd_if.o_rd_en), 32'(v.exp_rd));
      exp_q.push_back({v.de, v.hs, v.vs, v.exp_rgb});
      if (exp_q.size() == PIPE) begin
         e = exp_q.pop_front();
         check("out_de", 32'(o_de), 32'(e[26]));
         check("out_hsync", 32'(o_hsync), 32'(e[25]));
         check("out_vsync", 32'(o_vsync), 32'(e[24]));
         check("out_rgb", 32'(o_rgb), 32'(e[23:0]));
      end
   endtask

   task automatic run(input int lo, input int hi);
      for (int i = lo; i < hi; i++) step(vt[i]);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd_en"}, 32'(rd_if.o_rd_en), 32'd0);
      check({tag, "_x"}, 32'(rd_if.o_x), 32'd0);
      check({tag, "_y"}, 32'(rd_if.o_y), 32'd0);
      check({tag, "_rgb"}, 32'(o_rgb), 32'd0);
      check({tag, "_de"}, 32'(o_de), 32'd0);
      check({tag, "_hsync"}, 32'(o_hsync), 32'd0);
      check({tag, "_vsync"}, 32'(o_vsync), 32'd0);
      check({tag, "_status"}, 32'(o_status), 32'd0);
      check({tag, "_state"}, 32'(o_state), 32'd0);
   endtask

   int p_main, p_drop, p_stop, p_ovf, p_end;

   initial begin
      i_wr_completed = 1'b0;
      i_sx = '0; i_sy = '0; i_de = 1'b0; i_hsync = 1'b1; i_vsync = 1'b1; i_rgb = 24'h123456;
      i_win_x = 11'd100; i_win_y = 10'd50;
      extra_dv = 1'b0; drop_x = '1; drop_y = '1;

      // window (100,50) 128x304: columns 100..227, rows 50..353
      p_main = vt.size();
      vt.push_back(mk(1, 98, 50, 1, 1, 0, 24'h111111, 0, 24'h111111));
      vt.push_back(mk(1, 99, 50, 1, 0, 0, 24'h222222, 0, 24'h222222));
      vt.push_back(mk(1, 100, 50, 1, 0, 1, 24'h333333, 1, 24'hFFFFFF));
      vt.push_back(mk(1, 101, 50, 1, 1, 1, 24'h444444, 1, 24'h444444));
      vt.push_back(mk(1, 102, 50, 1, 0, 0, 24'h555555, 1, 24'h555555));
      vt.push_back(mk(1, 103, 50, 1, 0, 0, 24'h666666, 1, 24'hFFFFFF));
      vt.push_back(mk(1, 227, 50, 1, 0, 0, 24'h777777, 1, 24'h777777));
      vt.push_back(mk(1, 228, 50, 1, 0, 0, 24'h888888, 0, 24'h888888));
      vt.push_back(mk(1, 150, 49, 1, 0, 0, 24'h999999, 0, 24'h999999));
      vt.push_back(mk(1, 151, 353, 1, 0, 0, 24'hAAAAAA, 1, 24'hFFFFFF));
      vt.push_back(mk(1, 150, 354, 1, 0, 0, 24'hBBBBBB, 0, 24'hBBBBBB));
      vt.push_back(mk(1, 99, 353, 1, 0, 0, 24'hCCCCCC, 0, 24'hCCCCCC));
      vt.push_back(mk(1, 226, 353, 1, 0, 0, 24'hDDDDDD, 1, 24'hFFFFFF));
      vt.push_back(mk(1, 120, 60, 0, 1, 0, 24'hEEEEEE, 0, 24'h000000));
      vt.push_back(mk(1, 2000, 50, 1, 0, 0, 24'h123456, 0, 24'h123456));
      vt.push_back(mk(1, 125, 304, 1, 0, 0, 24'hABCDEF, 1, 24'hFFFFFF));
      for (int i = 0; i < 3; i++) vt.push_back(idle(1));
      // response for (106,50) withheld: pixel keeps its video
      p_drop = vt.size();
      vt.push_back(mk(1, 105, 50, 1, 0, 0, 24'h010101, 1, 24'h010101));
      vt.push_back(mk(1, 106, 50, 1, 0, 0, 24'h020202, 1, 24'h020202));
      vt.push_back(mk(1, 107, 50, 1, 0, 0, 24'h030303, 1, 24'h030303));
      vt.push_back(mk(1, 109, 50, 1, 0, 0, 24'h040404, 1, 24'hFFFFFF));
      for (int i = 0; i < 3; i++) vt.push_back(idle(1));
      // buffer invalidated mid-line: two requests in flight still composite
      p_stop = vt.size();
      vt.push_back(mk(1, 112, 50, 1, 0, 0, 24'h050505, 1, 24'hFFFFFF));
      vt.push_back(mk(1, 115, 50, 1, 0, 0, 24'h060606, 1, 24'hFFFFFF));
      vt.push_back(mk(0, 118, 50, 1, 0, 0, 24'h070707, 0, 24'h070707));
      vt.push_back(mk(0, 121, 50, 1, 0, 0, 24'h080808, 0, 24'h080808));
      for (int i = 0; i < 3; i++) vt.push_back(idle(0));
      // after overflow and flush
      p_ovf = vt.size();
      vt.push_back(mk(1, 100, 50, 1, 0, 0, 24'h101010, 1, 24'hFFFFFF));
      vt.push_back(mk(1, 101, 50, 1, 0, 0, 24'h202020, 1, 24'h202020));
      vt.push_back(mk(1, 102, 50, 1, 0, 0, 24'h303030, 1, 24'h303030));
      vt.push_back(mk(1, 103, 50, 1, 0, 0, 24'h404040, 1, 24'hFFFFFF));
      for (int i = 0; i < 3; i++) vt.push_back(idle(1));
      p_end = vt.size();

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      rst_n = 1'b1;

      // start a frame, then reset mid-line
      step(idle(1));
      step(mk(1, 0, 0, 0, 0, 0, 24'h0, 0, 24'h0));
      check("state_active", 32'(o_state), 32'd2);
      check("x_frame", 32'(rd_if.o_x), 32'd100);
      check("y_frame", 32'(rd_if.o_y), 32'd50);
      step(mk(1, 100, 50, 1, 0, 0, 24'h0A0A0A, 1, 24'hFFFFFF));
      step(mk(1, 101, 50, 1, 0, 0, 24'h0B0B0B, 1, 24'h0B0B0B));
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(mk(1, 102, 50, 1, 0, 0, 24'h0C0C0C, 0, 24'h0C0C0C));
      step(mk(1, 103, 50, 1, 0, 0, 24'h0D0D0D, 0, 24'h0D0D0D));
      step(mk(1, 104, 50, 1, 0, 0, 24'h0E0E0E, 0, 24'h0E0E0E));
      check("x_after_rst", 32'(rd_if.o_x), 32'd0);
      check("state_wait", 32'(o_state), 32'd1);
      step(mk(1, 0, 0, 0, 0, 0, 24'h0, 0, 24'h0));
      check("x_restart", 32'(rd_if.o_x), 32'd100);

      run(p_main, p_drop);
      check("status_main", 32'(o_status), 32'd0);

      drop_x = 11'd106; drop_y = 10'd50;
      run(p_drop, p_stop);
      drop_x = '1; drop_y = '1;
      check("status_underflow", 32'(o_status), STAT_EN ? 32'd1 : 32'd0);

      run(p_stop, p_ovf);
      check("state_idle", 32'(o_state), 32'd0);
      check("status_sticky", 32'(o_status), STAT_EN ? 32'd1 : 32'd0);

      // origin change mid-frame applies at the next frame start
      step(idle(1));
      step(mk(1, 0, 0, 0, 0, 0, 24'h0, 0, 24'h0));
      check("status_clear", 32'(o_status), 32'd0);
      check("x_before_move", 32'(rd_if.o_x), 32'd100);
      i_win_x = 11'd200;
      step(mk(1, 150, 60, 1, 0, 0, 24'h090909, 1, 24'hFFFFFF));
      check("x_mid_frame", 32'(rd_if.o_x), 32'd100);
      step(mk(1, 250, 60, 1, 0, 0, 24'h0A0B0C, 0, 24'h0A0B0C));
      step(mk(1, 0, 0, 0, 0, 0, 24'h0, 0, 24'h0));
      check("x_next_frame", 32'(rd_if.o_x), 32'd200);
      step(mk(1, 150, 60, 1, 0, 0, 24'h0D0D0D, 0, 24'h0D0D0D));
      step(mk(1, 250, 60, 1, 0, 0, 24'h0E0E0E, 1, 24'h0E0E0E));
      step(mk(1, 201, 60, 1, 0, 0, 24'h0F0F0F, 1, 24'hFFFFFF));
      for (int i = 0; i < 4; i++) step(idle(1));

      // nine unsolicited responses overflow the 8-deep FIFO
      i_win_x = 11'd100;
      extra_dv = 1'b1;
      for (int i = 0; i < 9; i++) step(idle(1));
      extra_dv = 1'b0;
      step(idle(1));
      check("status_overflow", 32'(o_status), STAT_EN ? 32'd2 : 32'd0);
      step(idle(0));
      step(idle(1));
      step(mk(1, 0, 0, 0, 0, 0, 24'h0, 0, 24'h0));
      check("status_flush", 32'(o_status), 32'd0);
      check("x_after_flush", 32'(rd_if.o_x), 32'd100);
      run(p_ovf, p_end);
      check("status_final", 32'(o_status), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
